pc_update: RTL
==============

Name: pc_update

Overview:
- Program-counter register plus next-PC selection for the single-cycle MIPS datapath.
- Sits directly downstream of the branch-offset shifter: it takes the word-aligned branch offset (sign-extended immediate << 2) and adds it to PC+4 to form the branch target.
- Also forms jump targets and supports stall and halt.
- Feeds pc_out to instruction memory and pc_plus4 to the register-file write path (jal).

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- PCWre  input  1  PC write enable; 0 = stall, so the PC holds.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = reserved.
- branch_taken  input  1  branch condition from the ALU zero logic; used only when PCSrc=01.
- offset_sl2  input  32  shifted sign-extended branch offset from the shifter.
- jump_index  input  26  instruction bits [25:0].
- halt_req  input  1  halt instruction decoded.
- pc_out  output  32  current PC.
- pc_plus4  output  32  pc_out + 4, combinational.
- halted  output  1  1 while in the HALT state.
- addr_err  output  1  sticky misaligned-target flag.

Behaviour:
- Reset (RST=0, asynchronous):
  - pc_out=PC_RESET, state=INIT, halted=0, addr_err=0.
  - Reset mid-operation aborts any pending update immediately.
- States: INIT, RUN, HALT.
- INIT:
  - Lasts exactly one cycle after reset release. The PC holds PC_RESET so the first instruction has a full fetch cycle.
  - Then goes to RUN unconditionally. Inputs are ignored.
- RUN, evaluated on each rising edge in this priority order:
  1. halt_req=1: state goes to HALT, PC holds, halted=1 from the next cycle.
  2. PCWre=0: PC holds, state stays RUN.
  3. Otherwise pc_out <= next_pc, where:
     - PCSrc=00: next_pc = pc_plus4.
     - PCSrc=01 and branch_taken=1: next_pc = pc_plus4 + offset_sl2 (mod 2^32; wrap-around is silent).
     - PCSrc=01 and branch_taken=0: next_pc = pc_plus4.
     - PCSrc=10: next_pc = {pc_plus4[31:28], jump_index, 2'b00}.
     - PCSrc=11: treated as 00 and sets addr_err.
  4. If the computed next_pc[1:0] != 0, it is a misaligned target:
     - addr_err <= 1 (sticky), PC is not updated, state goes to HALT.
- HALT:
  - PC frozen, halted=1. All inputs are ignored.
  - Exit only via reset.
- Latency: one cycle from select inputs to pc_out. pc_plus4 follows pc_out combinationally.
- Arithmetic: all adds are 32-bit unsigned, carry discarded. pc_plus4 at 32'hFFFF_FFFC wraps to 0.
- Simultaneous events:
  - halt_req together with PCWre=0: halt wins.
  - halt_req together with a misaligned target: halt wins, addr_err is not set.

Decomposition:
- Shared package/header (cpu_defs):
  - PCSrc encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_JMP=2'b10, PC_RSV=2'b11.
  - State encodings: S_INIT, S_RUN, S_HALT.
  - PC_RESET default.
- One natural sub-module: next_pc_sel, purely combinational. It computes next_pc and the misalign flag from pc_plus4, offset_sl2, jump_index, PCSrc and branch_taken.
- pc_update holds the register, the FSM and the sticky flags.

Test Plan:
- Reset and INIT:
  - Stimulus: RST=0, then released; PCSrc=00, PCWre=1 for 4 cycles.
  - Required: pc_out = 0, 0, 4, 8, 12 (the INIT hold is visible); halted=0.
- Branch:
  - Stimulus: pc_out=32'h0000_0010, PCSrc=01, branch_taken=1, offset_sl2=32'hFFFF_FFF0 (-16).
  - Required: next pc_out=32'h0000_0004.
  - With branch_taken=0 instead: required pc_out=32'h0000_0014.
- Jump:
  - Stimulus: pc_out=32'h4000_0100, PCSrc=10, jump_index=26'h0000040.
  - Required: pc_out=32'h4000_0100. The check is {4'h4, 26'h40, 2'b00}.
- Stall and wrap:
  - Stimulus: PCWre=0 for 3 cycles.
  - Required: pc_out unchanged.
  - Stimulus: pc_out=32'hFFFF_FFFC, PCSrc=00.
  - Required: pc_out=0, pc_plus4 wraps.
- Halt and misalign:
  - Stimulus: halt_req=1 at pc 32'h20.
  - Required: halted=1, pc stays 32'h20 over 5 cycles with varied inputs.
  - Stimulus (fresh run): offset_sl2=32'h2, branch taken.
  - Required: addr_err=1, halted=1, PC unchanged.
- Asynchronous reset mid-run:
  - Stimulus: RST pulled low between clock edges while pc=32'h40.
  - Required: pc_out=0 immediately, addr_err/halted cleared, INIT repeats.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the MIPS program-counter path.
// Next-PC select codes, PC FSM states and reset PC.
package cpu_defs;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_RSV = 2'b11;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: sequential, branch, jump.
// Flags misaligned targets and the reserved select code.
module next_pc_sel
  import cpu_defs::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] offset_sl2,
  input  logic [25:0] jump_index,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misalign,
  output logic        rsv_sel
);

  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  assign br_tgt  = pc_plus4 + offset_sl2;
  assign jmp_tgt = {pc_plus4[31:28], jump_index, 2'b00};

  // Select the target; reserved code falls back to PC+4.
  always_comb begin
    next_pc = pc_plus4;
    rsv_sel = 1'b0;
    unique case (1'b1)
      (pc_src == PC_BR):  next_pc = branch_taken ? br_tgt : pc_plus4;
      (pc_src == PC_JMP): next_pc = jmp_tgt;
      (pc_src == PC_RSV): rsv_sel = 1'b1;
      default:            next_pc = pc_plus4;
    endcase
  end

  assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_update.sv
// Program counter register with INIT/RUN/HALT control.
// Handles stall, halt and the sticky address-error flag.
module pc_update
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          WIDTH    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] offset_sl2,
  input  logic [25:0]      jump_index,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             halted,
  output logic             addr_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic        misalign;
  logic        rsv_sel;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel u_sel (
    .pc_plus4     (pc_plus4),
    .offset_sl2   (offset_sl2),
    .jump_index   (jump_index),
    .pc_src       (PCSrc),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misalign     (misalign),
    .rsv_sel      (rsv_sel)
  );

  // Next state: halt beats stall, stall beats update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (PCWre) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d = next_pc;
            if (rsv_sel) err_d = 1'b1;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_INIT;
      pc_q    <= PC_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign pc_out   = pc_q;
  assign halted   = (state_q == S_HALT);
  assign addr_err = err_q;

endmodule
